// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with 2-bit saturating counters: same-cycle fetch prediction,
// EX-stage mispredict detection/redirect, table training and saturating statistics.
module branch_predictor_btb #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned IDX_W   = 4,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              ex_valid,
    input  logic [ADDR_W-1:0] ex_pc,
    input  logic              ex_is_branch,
    input  logic              ex_is_jal,
    input  logic              ex_taken,
    input  logic [ADDR_W-1:0] ex_target,
    input  logic              ex_pred_taken,
    input  logic [ADDR_W-1:0] ex_pred_target,
    output logic              mispredict,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic [31:0]       br_count,
    output logic [31:0]       mp_count
);

    localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [ENTRIES-1:0] jal_q, jal_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [ADDR_W-1:0]  target_q [ENTRIES];
    logic [ADDR_W-1:0]  target_d [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [1:0]         ctr_d    [ENTRIES];
    logic [31:0]        br_count_q, br_count_d;
    logic [31:0]        mp_count_q, mp_count_d;

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic             if_hit, ex_hit;
    logic             unused_pc_lsbs;

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[ADDR_W-1:IDX_W+2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[ADDR_W-1:IDX_W+2];
    assign unused_pc_lsbs = ^{if_pc[1:0], ex_pc[1:0]};

    assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    // Lookup reads registered state only, so a same-cycle update is not bypassed.
    always_comb begin
        pred_taken  = if_hit && (jal_q[if_idx] || ctr_q[if_idx][1]);
        pred_target = pred_taken ? target_q[if_idx] : if_pc + ADDR_W'(4);
    end

    always_comb begin
        mispredict  = !rst && ex_valid &&
                      ((ex_taken != ex_pred_taken) ||
                       (ex_taken && (ex_target != ex_pred_target)));
        redirect_pc = '0;
        if (mispredict) begin
            redirect_pc = ex_taken ? ex_target : ex_pc + ADDR_W'(4);
        end
    end

    always_comb begin
        valid_d  = valid_q;
        jal_d    = jal_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (ex_valid) begin
            if (ex_is_jal) begin
                valid_d[ex_idx]  = 1'b1;
                jal_d[ex_idx]    = 1'b1;
                tag_d[ex_idx]    = ex_tag;
                target_d[ex_idx] = ex_target;
                ctr_d[ex_idx]    = 2'b11;
            end else if (ex_is_branch && ex_taken) begin
                if (ex_hit) begin
                    if (ctr_q[ex_idx] != 2'b11) begin
                        ctr_d[ex_idx] = ctr_q[ex_idx] + 2'b01;
                    end
                    target_d[ex_idx] = ex_target;
                end else begin
                    valid_d[ex_idx]  = 1'b1;
                    jal_d[ex_idx]    = 1'b0;
                    tag_d[ex_idx]    = ex_tag;
                    target_d[ex_idx] = ex_target;
                    ctr_d[ex_idx]    = 2'b10;
                end
            end else if (ex_is_branch) begin
                if (ex_hit && (ctr_q[ex_idx] != 2'b00)) begin
                    ctr_d[ex_idx] = ctr_q[ex_idx] - 2'b01;
                end
            end else if (ex_pred_taken && ex_hit) begin
                // A non-control instruction predicted taken is an alias: drop the entry.
                valid_d[ex_idx] = 1'b0;
            end
        end
    end

    always_comb begin
        br_count_d = br_count_q;
        mp_count_d = mp_count_q;
        if (ex_valid && (ex_is_branch || ex_is_jal) && (br_count_q != '1)) begin
            br_count_d = br_count_q + 32'd1;
        end
        if (mispredict && (mp_count_q != '1)) begin
            mp_count_d = mp_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= '0;
            jal_q      <= '0;
            br_count_q <= '0;
            mp_count_q <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else begin
            valid_q    <= valid_d;
            jal_q      <= jal_d;
            tag_q      <= tag_d;
            target_q   <= target_d;
            ctr_q      <= ctr_d;
            br_count_q <= br_count_d;
            mp_count_q <= mp_count_d;
        end
    end

    assign br_count = br_count_q;
    assign mp_count = mp_count_q;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Scenario bench for branch_predictor_btb: expected outputs are queued as each
// cycle is driven and popped for comparison before the next rising edge.
module tb_branch_predictor_btb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] if_pc = '0;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_pc = '0;
    logic        ex_is_branch = 1'b0;
    logic        ex_is_jal = 1'b0;
    logic        ex_taken = 1'b0;
    logic [31:0] ex_target = '0;
    logic        ex_pred_taken = 1'b0;
    logic [31:0] ex_pred_target = '0;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] br_count;
    logic [31:0] mp_count;

    branch_predictor_btb #(.ENTRIES(16), .IDX_W(4), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_is_branch(ex_is_branch),
        .ex_is_jal(ex_is_jal), .ex_taken(ex_taken), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .br_count(br_count), .mp_count(mp_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] ipc;
        logic        v;
        logic [31:0] pc;
        logic        br;
        logic        jal;
        logic        tk;
        logic [31:0] tg;
        logic        ptk;
        logic [31:0] ptg;
        logic        xpt;
        logic [31:0] xptg;
        logic        xmp;
        logic [31:0] xrpc;
    } stim_t;

    logic [65:0] sbq[$];
    logic [65:0] e, obs;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] exp_br = '0;
    logic [31:0] exp_mp = '0;

    function automatic stim_t st(input logic [31:0] ipc, input logic v, input logic [31:0] pc,
                                 input logic br, input logic jal, input logic tk,
                                 input logic [31:0] tg, input logic ptk, input logic [31:0] ptg,
                                 input logic xpt, input logic [31:0] xptg,
                                 input logic xmp, input logic [31:0] xrpc);
        stim_t s;
        s.ipc = ipc; s.v = v; s.pc = pc; s.br = br; s.jal = jal; s.tk = tk;
        s.tg = tg; s.ptk = ptk; s.ptg = ptg; s.xpt = xpt; s.xptg = xptg;
        s.xmp = xmp; s.xrpc = xrpc;
        return s;
    endfunction

    // Apply one cycle of stimulus and queue the outputs it must produce.
    task automatic drive(input stim_t s);
        if_pc          = s.ipc;
        ex_valid       = s.v;
        ex_pc          = s.pc;
        ex_is_branch   = s.br;
        ex_is_jal      = s.jal;
        ex_taken       = s.tk;
        ex_target      = s.tg;
        ex_pred_taken  = s.ptk;
        ex_pred_target = s.ptg;
        sbq.push_back({s.xpt, s.xptg, s.xmp, s.xrpc});
        if (s.v && (s.br || s.jal) && exp_br != 32'hFFFFFFFF) exp_br = exp_br + 1;
        if (s.xmp && exp_mp != 32'hFFFFFFFF) exp_mp = exp_mp + 1;
    endtask

    task automatic test_reset();
        stim_t s[$];
        s.push_back(st(32'h100, 0, 32'h100, 1, 0, 1, 32'h80, 0, 32'h104, 0, 32'h104, 0, 0));
        foreach (s[i]) begin
            drive(s[i]);
            #2;
            e = sbq.pop_front();
            obs = {pred_taken, pred_target, mispredict, redirect_pc};
            n_checks++;
            if (obs !== e) $display("FAIL reset_out[%0d]: got %h, expected %h", i, obs, e);
            else n_pass++;
        end
        n_checks++;
        if (br_count !== exp_br || mp_count !== exp_mp)
            $display("FAIL reset_counters: got br=%h mp=%h, expected br=%h mp=%h", br_count, mp_count, exp_br, exp_mp);
        else n_pass++;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_cold_start();
        stim_t s[$];
        s.push_back(st(32'h100, 1, 32'h100, 1, 0, 1, 32'h80, 0, 32'h104, 0, 32'h104, 1, 32'h80));
        s.push_back(st(32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h80, 0, 0));
        foreach (s[i]) begin
            drive(s[i]);
            #2;
            e = sbq.pop_front();
            obs = {pred_taken, pred_target, mispredict, redirect_pc};
            n_checks++;
            if (obs !== e) $display("FAIL cold_start[%0d]: got %h, expected %h", i, obs, e);
            else n_pass++;
            @(posedge clk); @(negedge clk);
        end
        n_checks++;
        if (br_count !== exp_br || mp_count !== exp_mp)
            $display("FAIL cold_start_counters: got br=%h mp=%h, expected br=%h mp=%h", br_count, mp_count, exp_br, exp_mp);
        else n_pass++;
    endtask

    task automatic test_training();
        stim_t s[$];
        // counter 10 -> 11 -> 11 -> 10 -> 01 -> 00, then a taken moves it only to 01
        s.push_back(st(32'h100, 1, 32'h100, 1, 0, 1, 32'h80, 1, 32'h80,  1, 32'h80,  0, 0));
        s.push_back(st(32'h100, 1, 32'h100, 1, 0, 1, 32'h80, 1, 32'h80,  1, 32'h80,  0, 0));
        s.push_back(st(32'h100, 1, 32'h100, 1, 0, 0, 32'h80, 1, 32'h80,  1, 32'h80,  1, 32'h104));
        s.push_back(st(32'h100, 1, 32'h100, 1, 0, 0, 32'h80, 1, 32'h80,  1, 32'h80,  1, 32'h104));
        s.push_back(st(32'h100, 1, 32'h100, 1, 0, 0, 32'h80, 0, 32'h104, 0, 32'h104, 0, 0));
        s.push_back(st(32'h100, 1, 32'h100, 1, 0, 1, 32'h80, 0, 32'h104, 0, 32'h104, 1, 32'h80));
        s.push_back(st(32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h104, 0, 0));
        foreach (s[i]) begin
            drive(s[i]);
            #2;
            e = sbq.pop_front();
            obs = {pred_taken, pred_target, mispredict, redirect_pc};
            n_checks++;
            if (obs !== e) $display("FAIL training[%0d]: got %h, expected %h", i, obs, e);
            else n_pass++;
            @(posedge clk); @(negedge clk);
        end
        n_checks++;
        if (br_count !== exp_br || mp_count !== exp_mp)
            $display("FAIL training_counters: got br=%h mp=%h, expected br=%h mp=%h", br_count, mp_count, exp_br, exp_mp);
        else n_pass++;
    endtask

    task automatic test_jal();
        stim_t s[$];
        s.push_back(st(32'h200, 1, 32'h200, 0, 1, 1, 32'h400, 0, 32'h204, 0, 32'h204, 1, 32'h400));
        for (int k = 0; k < 3; k++)
            s.push_back(st(32'h200, 1, 32'h200, 0, 1, 1, 32'h400, 1, 32'h400, 1, 32'h400, 0, 0));
        foreach (s[i]) begin
            drive(s[i]);
            #2;
            e = sbq.pop_front();
            obs = {pred_taken, pred_target, mispredict, redirect_pc};
            n_checks++;
            if (obs !== e) $display("FAIL jal[%0d]: got %h, expected %h", i, obs, e);
            else n_pass++;
            @(posedge clk); @(negedge clk);
        end
        n_checks++;
        if (br_count !== exp_br || mp_count !== exp_mp)
            $display("FAIL jal_counters: got br=%h mp=%h, expected br=%h mp=%h", br_count, mp_count, exp_br, exp_mp);
        else n_pass++;
    endtask

    task automatic test_alias();
        stim_t s[$];
        s.push_back(st(32'h100, 1, 32'h100, 1, 0, 1, 32'h80,  0, 32'h104, 0, 32'h104, 1, 32'h80));
        s.push_back(st(32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h80, 0, 0));
        s.push_back(st(32'h140, 1, 32'h140, 1, 0, 1, 32'h300, 0, 32'h144, 0, 32'h144, 1, 32'h300));
        s.push_back(st(32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h104, 0, 0));
        s.push_back(st(32'h140, 1, 32'h100, 0, 0, 0, 0, 1, 32'h80,  1, 32'h300, 1, 32'h104));
        s.push_back(st(32'h140, 1, 32'h140, 0, 0, 0, 0, 1, 32'h300, 1, 32'h300, 1, 32'h144));
        s.push_back(st(32'h140, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h144, 0, 0));
        foreach (s[i]) begin
            drive(s[i]);
            #2;
            e = sbq.pop_front();
            obs = {pred_taken, pred_target, mispredict, redirect_pc};
            n_checks++;
            if (obs !== e) $display("FAIL alias[%0d]: got %h, expected %h", i, obs, e);
            else n_pass++;
            @(posedge clk); @(negedge clk);
        end
        n_checks++;
        if (br_count !== exp_br || mp_count !== exp_mp)
            $display("FAIL alias_counters: got br=%h mp=%h, expected br=%h mp=%h", br_count, mp_count, exp_br, exp_mp);
        else n_pass++;
    endtask

    task automatic test_corner();
        stim_t s[$];
        s.push_back(st(32'h184, 0, 32'h184, 1, 0, 1, 32'h500, 0, 32'h188, 0, 32'h188, 0, 0));
        s.push_back(st(32'h184, 1, 32'h184, 1, 0, 1, 32'h500, 0, 32'h188, 0, 32'h188, 1, 32'h500));
        s.push_back(st(32'h184, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h500, 0, 0));
        foreach (s[i]) begin
            drive(s[i]);
            #2;
            e = sbq.pop_front();
            obs = {pred_taken, pred_target, mispredict, redirect_pc};
            n_checks++;
            if (obs !== e) $display("FAIL corner[%0d]: got %h, expected %h", i, obs, e);
            else n_pass++;
            @(posedge clk); @(negedge clk);
        end
        n_checks++;
        if (br_count !== exp_br || mp_count !== exp_mp)
            $display("FAIL corner_counters: got br=%h mp=%h, expected br=%h mp=%h", br_count, mp_count, exp_br, exp_mp);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        stim_t s[$];
        drive(st(32'h184, 1, 32'h188, 0, 1, 1, 32'h600, 0, 32'h18C, 1, 32'h500, 1, 32'h600));
        #2;
        e = sbq.pop_front();
        obs = {pred_taken, pred_target, mispredict, redirect_pc};
        n_checks++;
        if (obs !== e) $display("FAIL reset_mid_pre: got %h, expected %h", obs, e);
        else n_pass++;
        #1 rst = 1'b1;
        exp_br = '0;
        exp_mp = '0;
        #1;
        obs = {pred_taken, pred_target, mispredict, redirect_pc};
        n_checks++;
        if (obs !== {1'b0, 32'h188, 1'b0, 32'h0} || br_count !== 32'h0 || mp_count !== 32'h0)
            $display("FAIL reset_mid_async: got out=%h br=%h mp=%h, expected out=%h br=0 mp=0",
                     obs, br_count, mp_count, {1'b0, 32'h188, 1'b0, 32'h0});
        else n_pass++;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        s.push_back(st(32'h188, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h18C, 0, 0));
        s.push_back(st(32'h184, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h188, 0, 0));
        foreach (s[i]) begin
            drive(s[i]);
            #2;
            e = sbq.pop_front();
            obs = {pred_taken, pred_target, mispredict, redirect_pc};
            n_checks++;
            if (obs !== e) $display("FAIL reset_mid_post[%0d]: got %h, expected %h", i, obs, e);
            else n_pass++;
            @(posedge clk); @(negedge clk);
        end
        n_checks++;
        if (br_count !== exp_br || mp_count !== exp_mp)
            $display("FAIL reset_mid_counters: got br=%h mp=%h, expected br=%h mp=%h", br_count, mp_count, exp_br, exp_mp);
        else n_pass++;
    endtask

    task automatic test_saturation();
        stim_t s[$];
        force dut.mp_count_q = 32'hFFFFFFFE;
        #1 release dut.mp_count_q;
        exp_mp = 32'hFFFFFFFE;
        for (int k = 0; k < 3; k++)
            s.push_back(st(32'hFFFFFFFC, 1, 32'hFFFFFFFC, 1, 0, 0, 32'h10, 1, 32'h10, 0, 32'h0, 1, 32'h0));
        foreach (s[i]) begin
            drive(s[i]);
            #2;
            e = sbq.pop_front();
            obs = {pred_taken, pred_target, mispredict, redirect_pc};
            n_checks++;
            if (obs !== e) $display("FAIL saturation[%0d]: got %h, expected %h", i, obs, e);
            else n_pass++;
            @(posedge clk); @(negedge clk);
        end
        n_checks++;
        if (br_count !== exp_br || mp_count !== exp_mp)
            $display("FAIL saturation_counters: got br=%h mp=%h, expected br=%h mp=%h", br_count, mp_count, exp_br, exp_mp);
        else n_pass++;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_cold_start();
        test_training();
        test_jal();
        test_alias();
        test_corner();
        test_reset_mid();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
